// File: rtl/wb_commit_checker.sv
// wb_commit_checker: in-order commit monitor for regfile writes and stores.
// Compares snooped events against two preloaded expected-event queues.
module wb_commit_checker #(
  parameter int XLEN         = 32,
  parameter int RAW          = 5,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 64,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            exp_wr_i,
  input  logic            exp_kind_i,
  input  logic [XLEN-1:0] exp_addr_i,
  input  logic [XLEN-1:0] exp_data_i,
  input  logic            start_i,
  input  logic            we3_i,
  input  logic [RAW-1:0]  a3_i,
  input  logic [XLEN-1:0] wd3_i,
  input  logic            memwrite_i,
  input  logic [XLEN-1:0] maddr_i,
  input  logic [XLEN-1:0] mwdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic            fail_o,
  output logic            timeout_o,
  output logic            load_err_o,
  output logic [15:0]     match_cnt_o,
  output logic [15:0]     mismatch_cnt_o,
  output logic [XLEN-1:0] first_fail_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;

  logic [RAW-1:0]  rq_addr [DEPTH];
  logic [XLEN-1:0] rq_data [DEPTH];
  logic [XLEN-1:0] sq_addr [DEPTH];
  logic [XLEN-1:0] sq_data [DEPTH];

  logic [PW-1:0] rq_wp, rq_rp, sq_wp, sq_rp;
  logic [CW-1:0] rq_cnt, sq_cnt, rq_nxt, sq_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic          mis_seen;

  logic load, run, push_r, push_s, full_hit;
  logic r_ev, s_ev, r_hit, s_hit, r_pop, s_pop;
  logic r_mis, s_mis, to_hit;
  logic [1:0] n_match, n_mis;

  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [1:0]  b
  );
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign load   = state == IDLE && !clear_i && exp_wr_i;
  assign run    = state == RUN;
  assign push_r = load && !exp_kind_i && rq_cnt != FULL;
  assign push_s = load && exp_kind_i && sq_cnt != FULL;
  assign full_hit = load && (exp_kind_i ? sq_cnt == FULL
                                        : rq_cnt == FULL);

  assign r_ev  = run && we3_i && a3_i != '0;
  assign s_ev  = run && memwrite_i;
  assign r_hit = rq_cnt != '0 && a3_i == rq_addr[rq_rp]
                 && wd3_i == rq_data[rq_rp];
  assign s_hit = sq_cnt != '0 && maddr_i == sq_addr[sq_rp]
                 && mwdata_i == sq_data[sq_rp];
  assign r_pop = r_ev && rq_cnt != '0;
  assign s_pop = s_ev && sq_cnt != '0;
  assign r_mis = r_ev && !r_hit;
  assign s_mis = s_ev && !s_hit;

  assign n_match = {1'b0, r_ev && r_hit} + {1'b0, s_ev && s_hit};
  assign n_mis   = {1'b0, r_mis} + {1'b0, s_mis};

  assign rq_nxt = rq_cnt + CW'(push_r) - CW'(r_pop);
  assign sq_nxt = sq_cnt + CW'(push_s) - CW'(s_pop);

  assign idle_nxt = idle_cnt + IW'(1);
  assign to_hit   = run && !r_ev && !s_ev && idle_nxt == IW'(TIMEOUT);

  assign busy_o = state == RUN;
  assign done_o = state == DONE;
  assign fail_o = mis_seen | timeout_o | load_err_o;
  assign pass_o = done_o & ~fail_o;

  // Expected-entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_r) begin
      rq_addr[rq_wp] <= exp_addr_i[RAW-1:0];
      rq_data[rq_wp] <= exp_data_i;
    end
    if (push_s) begin
      sq_addr[sq_wp] <= exp_addr_i;
      sq_data[sq_wp] <= exp_data_i;
    end
  end

  // Control FSM, queue pointers, counters and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rq_wp          <= '0;
      rq_rp          <= '0;
      sq_wp          <= '0;
      sq_rp          <= '0;
      rq_cnt         <= '0;
      sq_cnt         <= '0;
      idle_cnt       <= '0;
      mis_seen       <= 1'b0;
      timeout_o      <= 1'b0;
      load_err_o     <= 1'b0;
      match_cnt_o    <= '0;
      mismatch_cnt_o <= '0;
      first_fail_o   <= '0;
    end else if (clear_i) begin
      state          <= IDLE;
      rq_wp          <= '0;
      rq_rp          <= '0;
      sq_wp          <= '0;
      sq_rp          <= '0;
      rq_cnt         <= '0;
      sq_cnt         <= '0;
      idle_cnt       <= '0;
      mis_seen       <= 1'b0;
      timeout_o      <= 1'b0;
      load_err_o     <= 1'b0;
      match_cnt_o    <= '0;
      mismatch_cnt_o <= '0;
      first_fail_o   <= '0;
    end else begin
      if (push_r) rq_wp <= rq_wp + PW'(1);
      if (push_s) sq_wp <= sq_wp + PW'(1);
      if (r_pop)  rq_rp <= rq_rp + PW'(1);
      if (s_pop)  sq_rp <= sq_rp + PW'(1);
      rq_cnt <= rq_nxt;
      sq_cnt <= sq_nxt;
      if (full_hit) load_err_o <= 1'b1;
      match_cnt_o    <= sat_add(match_cnt_o, n_match);
      mismatch_cnt_o <= sat_add(mismatch_cnt_o, n_mis);
      if (r_mis || s_mis) begin
        mis_seen <= 1'b1;
        if (!mis_seen) first_fail_o <= r_mis ? wd3_i : mwdata_i;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            idle_cnt <= '0;
            state    <= (rq_nxt == '0 && sq_nxt == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          idle_cnt <= (r_ev || s_ev) ? '0 : idle_nxt;
          if (to_hit) timeout_o <= 1'b1;
          if (to_hit || (rq_nxt == '0 && sq_nxt == '0)
              || (STOP_ON_FAIL != 0 && (r_mis || s_mis)))
            state <= DONE;
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
